// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback arbiter slice.
package rf_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]   xword_t;

  typedef enum logic {CLEAR, RUN} rfarb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester writeback arbiter: round-robin by default, fixed load priority
// when RFARB_LOAD_PRIORITY_EN is defined.
module rr_arb2 (
`ifndef RFARB_LOAD_PRIORITY_EN
  input  logic clk_i,
  input  logic rst_i,
`endif
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

`ifdef RFARB_LOAD_PRIORITY_EN

  // Load results always win a tie; the ALU only gets the port when loads are idle.
  always_comb begin
    gnt1_o = en_i && req1_i;
    gnt0_o = en_i && req0_i && !req1_i;
  end

`else

  logic ptr_q, ptr_d;

  // A grant is always an accepted transfer, so the pointer moves to the other port.
  always_comb begin
    gnt0_o = en_i && req0_i && (!req1_i || !ptr_q);
    gnt1_o = en_i && req1_i && (!req0_i || ptr_q);
    ptr_d  = ptr_q;
    if (gnt0_o) begin
      ptr_d = 1'b1;
    end else if (gnt1_o) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sequences the register-file write port: post-reset clear sweep of x1..x31, then
// arbitration between ALU and load writebacks. See RFARB_LOAD_PRIORITY_EN in rr_arb2.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int NREGS          = NREGS_DEF,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_w,
  output logic [XLEN-1:0] rf_d,
  output logic            init_done
);

  rfarb_state_t    state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rf_wen_q, rf_wen_d;
  logic [AW-1:0]   rf_w_q, rf_w_d;
  logic [XLEN-1:0] rf_d_q, rf_d_d;
  logic            init_done_q, init_done_d;
  logic            gnt0, gnt1;

  rr_arb2 u_arb (
`ifndef RFARB_LOAD_PRIORITY_EN
    .clk_i  (clk),
    .rst_i  (rst),
`endif
    .en_i   (state_q == RUN),
    .req0_i (wb0_valid),
    .req1_i (wb1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign wb0_ready = gnt0;
  assign wb1_ready = gnt1;

  // Address/data only change on a real write so an idle port holds its last values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_wen_d    = 1'b0;
    rf_w_d      = rf_w_q;
    rf_d_d      = rf_d_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        rf_wen_d = 1'b1;
        rf_w_d   = cnt_q;
        rf_d_d   = '0;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        // x0 writes are accepted but swallowed here.
        if (gnt0) begin
          if (wb0_rd != '0) begin
            rf_wen_d = 1'b1;
            rf_w_d   = wb0_rd;
            rf_d_d   = wb0_data;
          end
        end else if (gnt1) begin
          if (wb1_rd != '0) begin
            rf_wen_d = 1'b1;
            rf_w_d   = wb1_rd;
            rf_d_d   = wb1_data;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q       <= AW'(1);
      rf_wen_q    <= 1'b0;
      rf_w_q      <= '0;
      rf_d_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_wen_q    <= rf_wen_d;
      rf_w_q      <= rf_w_d;
      rf_d_q      <= rf_d_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_w      = rf_w_q;
  assign rf_d      = rf_d_q;
  assign init_done = init_done_q;

endmodule
